// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: statistics selector values and the
// RegWrite load-type codes carried down the pipeline.
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    STAT_HITS     = 2'd0,
    STAT_MISSES   = 2'd1,
    STAT_MISS_CYC = 2'd2,
    STAT_HOLD_CYC = 2'd3
  } stat_sel_e;

  typedef enum logic [2:0] {
    RW_NONE  = 3'd0,
    RW_WORD  = 3'd1,
    RW_BYTE  = 3'd2,
    RW_HALF  = 3'd3,
    RW_BYTEU = 3'd4,
    RW_HALFU = 3'd5
  } rw_code_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the MEM/WB stage (master) and the
// external cache (slave).
interface mem_wb_stage_if #(
  parameter int XLEN = 32
);
  logic              req;
  logic [XLEN/8-1:0] we;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              ready;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, wdata, input  ready, rdata);
  modport slave  (input  req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_wb_stage_stat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets its default before any branch, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = '0;
    else if (inc && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so all registers sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline segment: issues one cache access per MEM instruction,
// registers write-back fields and keeps hit/miss/stall statistics.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int RW_W  = 3,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  output logic                       stall_mem,
  input  logic [XLEN-1:0]            a_m,
  input  logic [XLEN-1:0]            wd_m,
  input  logic [XLEN/8-1:0]          we_m,
  input  logic                       memtoreg_m,
  mem_wb_stage_if.master             mem,
  output logic [XLEN-1:0]            rdata_w,
  output logic [$clog2(XLEN/8)-1:0]  lbs_w,
  input  logic [XLEN-1:0]            result_m,
  output logic [XLEN-1:0]            result_w,
  input  logic [RD_W-1:0]            rd_m,
  output logic [RD_W-1:0]            rd_w,
  input  logic [RW_W-1:0]            regwrite_m,
  output logic [RW_W-1:0]            regwrite_w,
  output logic                       memtoreg_w,
  input  logic [1:0]                 stat_sel,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           stat_data
);

  localparam int LBS_W = $clog2(XLEN/8);

  logic            acc, first;
  logic            done_q, done_d, pend_q, pend_d;
  logic [XLEN-1:0] hold_q, hold_d;

  logic [XLEN-1:0]  rdata_q, rdata_d, result_q, result_d;
  logic [LBS_W-1:0] lbs_q, lbs_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [RW_W-1:0]  regwrite_q, regwrite_d;
  logic             memtoreg_q, memtoreg_d;

  // done blocks a repeat request once the held instruction's access completed
  assign acc       = memtoreg_m | (|we_m);
  assign mem.req   = acc & ~done_q;
  assign mem.we    = mem.req ? we_m : '0;
  assign mem.addr  = a_m;
  assign mem.wdata = wd_m;
  assign stall_mem = mem.req & ~mem.ready;
  assign first     = acc & ~pend_q & ~done_q;

  always_comb begin
    done_d = done_q;
    hold_d = hold_q;
    pend_d = pend_q;
    if (en) begin
      done_d = 1'b0;
    end else if (acc && mem.ready && !done_q) begin
      done_d = 1'b1;
      hold_d = mem.rdata;
    end
    // pend tracks an unanswered request, so a completed-but-held access never looks pending
    if (stall_mem)                pend_d = 1'b1;
    else if (mem.ready || !acc)   pend_d = 1'b0;
  end

  always_comb begin
    rdata_d    = rdata_q;
    lbs_d      = lbs_q;
    result_d   = result_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    if (en) begin
      if (clr) begin
        rdata_d    = '0;
        lbs_d      = '0;
        result_d   = '0;
        rd_d       = '0;
        regwrite_d = RW_W'(RW_NONE);
        memtoreg_d = 1'b0;
      end else begin
        rdata_d    = done_q ? hold_q : mem.rdata;
        lbs_d      = a_m[LBS_W-1:0];
        result_d   = result_m;
        rd_d       = rd_m;
        regwrite_d = regwrite_m;
        memtoreg_d = memtoreg_m;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      hold_q     <= '0;
      rdata_q    <= '0;
      lbs_q      <= '0;
      result_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= '0;
      memtoreg_q <= 1'b0;
    end else begin
      done_q     <= done_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      rdata_q    <= rdata_d;
      lbs_q      <= lbs_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
    end
  end

  assign rdata_w    = rdata_q;
  assign lbs_w      = lbs_q;
  assign result_w   = result_q;
  assign rd_w       = rd_q;
  assign regwrite_w = regwrite_q;
  assign memtoreg_w = memtoreg_q;

  logic [CNT_W-1:0] hits, misses, miss_cyc, hold_cyc;

  stat_counter #(.CNT_W(CNT_W)) u_hits (
    .clk(clk), .rst(rst), .clr(stat_clr), .inc(first & mem.ready), .cnt(hits));
  stat_counter #(.CNT_W(CNT_W)) u_misses (
    .clk(clk), .rst(rst), .clr(stat_clr), .inc(first & ~mem.ready), .cnt(misses));
  stat_counter #(.CNT_W(CNT_W)) u_miss_cyc (
    .clk(clk), .rst(rst), .clr(stat_clr), .inc(stall_mem), .cnt(miss_cyc));
  stat_counter #(.CNT_W(CNT_W)) u_hold_cyc (
    .clk(clk), .rst(rst), .clr(stat_clr), .inc(~en), .cnt(hold_cyc));

  always_comb begin
    stat_data = '0;
    case (stat_sel_e'(stat_sel))
      STAT_HITS:     stat_data = hits;
      STAT_MISSES:   stat_data = misses;
      STAT_MISS_CYC: stat_data = miss_cyc;
      STAT_HOLD_CYC: stat_data = hold_cyc;
      default:       stat_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: write-back fields are scoreboarded
// against expectations queued when each enabled edge is set up.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en, clr, stall_mem, memtoreg_m, memtoreg_w, stat_clr;
  logic [31:0] a_m, wd_m, rdata_w, result_m, result_w;
  logic [3:0]  we_m;
  logic [1:0]  lbs_w, stat_sel;
  logic [4:0]  rd_m, rd_w;
  logic [2:0]  regwrite_m, regwrite_w;
  logic [3:0]  stat_data;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  lbs;
    logic [31:0] result;
    logic [4:0]  rd;
    logic [2:0]  rw;
    logic        mtr;
  } wb_t;
  wb_t exp_q[$];

  always #5 clk = ~clk;

  mem_wb_stage_if #(.XLEN(32)) bus ();

  mem_wb_stage #(.XLEN(32), .RD_W(5), .RW_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .stall_mem(stall_mem),
    .a_m(a_m), .wd_m(wd_m), .we_m(we_m), .memtoreg_m(memtoreg_m),
    .mem(bus),
    .rdata_w(rdata_w), .lbs_w(lbs_w),
    .result_m(result_m), .result_w(result_w),
    .rd_m(rd_m), .rd_w(rd_w),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_w(memtoreg_w),
    .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_data(stat_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memtoreg_m = 1'b0; we_m = '0; a_m = '0; wd_m = '0;
    result_m = '0; rd_m = '0; regwrite_m = '0;
  endtask

  task automatic drive(input logic mtr, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] res,
                       input logic [4:0] rd, input logic [2:0] rw);
    memtoreg_m = mtr; we_m = we; a_m = a; wd_m = wd;
    result_m = res; rd_m = rd; regwrite_m = rw;
  endtask

  task automatic expect_wb(input logic [31:0] rdata, input logic [31:0] a,
                           input logic [31:0] res, input logic [4:0] rd,
                           input logic [2:0] rw, input logic mtr);
    wb_t e;
    e.rdata = rdata; e.lbs = a[1:0]; e.result = res;
    e.rd = rd; e.rw = rw; e.mtr = mtr;
    exp_q.push_back(e);
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".rdata_w"},    rdata_w,    e.rdata);
      check({tag, ".lbs_w"},      lbs_w,      e.lbs);
      check({tag, ".result_w"},   result_w,   e.result);
      check({tag, ".rd_w"},       rd_w,       e.rd);
      check({tag, ".regwrite_w"}, regwrite_w, e.rw);
      check({tag, ".memtoreg_w"}, memtoreg_w, e.mtr);
    end
  endtask

  task automatic check_stat(input string tag, input logic [1:0] sel, input logic [3:0] exp);
    stat_sel = sel;
    #1;
    check(tag, stat_data, exp);
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, ".rdata_w"},    rdata_w,    0);
    check({tag, ".lbs_w"},      lbs_w,      0);
    check({tag, ".result_w"},   result_w,   0);
    check({tag, ".rd_w"},       rd_w,       0);
    check({tag, ".regwrite_w"}, regwrite_w, 0);
    check({tag, ".memtoreg_w"}, memtoreg_w, 0);
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s);
      #1;
      check($sformatf("%s.stat%0d", tag, s), stat_data, 0);
    end
  endtask

  task automatic clear_stats();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
  endtask

  initial begin
    en = 1'b1; clr = 1'b0; stat_clr = 1'b0; stat_sel = '0;
    idle();
    bus.ready = 1'b0;
    bus.rdata = '0;

    // reset state
    tick(); tick();
    check_zero_state("reset_held");
    rst = 1'b0;
    tick();
    check_zero_state("reset_idle");

    // load hit
    drive(1'b1, 4'h0, 32'h0000_1003, 32'h0, 32'h0000_1111, 5'd7, RW_WORD);
    bus.ready = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    #1;
    check("hit.mem_req", bus.req, 1);
    check("hit.stall", stall_mem, 0);
    check("hit.mem_we", bus.we, 0);
    check("hit.mem_addr", bus.addr, 32'h0000_1003);
    expect_wb(32'hDEAD_BEEF, 32'h0000_1003, 32'h0000_1111, 5'd7, RW_WORD, 1'b1);
    tick();
    check_wb("hit");
    idle();
    check_stat("hit.hits", STAT_HITS, 4'd1);
    check_stat("hit.misses", STAT_MISSES, 4'd0);

    // load miss, held three cycles by the hazard unit
    clear_stats();
    drive(1'b1, 4'h0, 32'h0000_2001, 32'h0, 32'h0000_2222, 5'd9, RW_BYTE);
    bus.ready = 1'b0;
    bus.rdata = 32'h1111_1111;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("miss.stall%0d", i), stall_mem, 1);
      check($sformatf("miss.rdata_hold%0d", i), rdata_w, 32'hDEAD_BEEF);
      tick();
    end
    bus.ready = 1'b1;
    bus.rdata = 32'hCAFE_F00D;
    en = 1'b1;
    #1;
    check("miss.stall_done", stall_mem, 0);
    expect_wb(32'hCAFE_F00D, 32'h0000_2001, 32'h0000_2222, 5'd9, RW_BYTE, 1'b1);
    tick();
    check_wb("miss");
    idle();
    check_stat("miss.misses", STAT_MISSES, 4'd1);
    check_stat("miss.miss_cyc", STAT_MISS_CYC, 4'd3);
    check_stat("miss.hold_cyc", STAT_HOLD_CYC, 4'd3);
    check_stat("miss.hits", STAT_HITS, 4'd0);

    // store hit while held for four cycles: one request, data from hold register
    clear_stats();
    drive(1'b0, 4'hF, 32'h0000_3002, 32'h1234_5678, 32'h0000_3333, 5'd0, RW_NONE);
    bus.ready = 1'b1;
    bus.rdata = 32'hA5A5_A5A5;
    en = 1'b0;
    #1;
    check("held.req_first", bus.req, 1);
    check("held.we_first", bus.we, 4'hF);
    check("held.wdata", bus.wdata, 32'h1234_5678);
    tick();
    bus.rdata = 32'h5A5A_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("held.req_off%0d", i), bus.req, 0);
      check($sformatf("held.we_off%0d", i), bus.we, 0);
      check($sformatf("held.stall%0d", i), stall_mem, 0);
      tick();
    end
    en = 1'b1;
    #1;
    check("held.req_release", bus.req, 0);
    expect_wb(32'hA5A5_A5A5, 32'h0000_3002, 32'h0000_3333, 5'd0, RW_NONE, 1'b0);
    tick();
    check_wb("held");
    check("held.req_after_release", bus.req, 1);
    idle();
    check_stat("held.hits", STAT_HITS, 4'd1);
    check_stat("held.misses", STAT_MISSES, 4'd0);
    check_stat("held.hold_cyc", STAT_HOLD_CYC, 4'd4);
    check_stat("held.miss_cyc", STAT_MISS_CYC, 4'd0);

    // flush
    drive(1'b1, 4'h0, 32'h0000_4003, 32'h0, 32'h0000_4444, 5'd5, 3'd2);
    bus.ready = 1'b1;
    bus.rdata = 32'h7777_7777;
    clr = 1'b1;
    expect_wb(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0);
    tick();
    check_wb("flush");
    clr = 1'b0;
    idle();

    // saturation of the hit counter, then clear beating a same-cycle hit
    clear_stats();
    drive(1'b1, 4'h0, 32'h0, 32'h0, 32'h0000_5555, 5'd0, RW_WORD);
    bus.ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      bus.rdata = 32'(i) * 32'h0101_0101;
      rd_m = 5'(i);
      a_m = 32'(i);
      expect_wb(32'(i) * 32'h0101_0101, 32'(i), 32'h0000_5555, 5'(i), RW_WORD, 1'b1);
      tick();
      check_wb($sformatf("sat%0d", i));
      if (i == 3)  check_stat("sat.hits3", STAT_HITS, 4'd3);
      if (i == 15) check_stat("sat.hits15", STAT_HITS, 4'hF);
      if (i == 17) check_stat("sat.hits17", STAT_HITS, 4'hF);
    end
    stat_clr = 1'b1;
    bus.rdata = 32'h0BAD_F00D;
    expect_wb(32'h0BAD_F00D, 32'(17), 32'h0000_5555, 5'd17, RW_WORD, 1'b1);
    tick();
    stat_clr = 1'b0;
    check_wb("sat_clr");
    check_stat("sat.clr_hits", STAT_HITS, 4'd0);
    idle();

    // reset in the middle of a miss; the access is counted again afterwards
    drive(1'b1, 4'h0, 32'h0000_6000, 32'h0, 32'h0000_6666, 5'd3, RW_HALF);
    bus.ready = 1'b0;
    en = 1'b0;
    tick();
    check("rmiss.stall_pre", stall_mem, 1);
    rst = 1'b1;
    #1;
    check_zero_state("rmiss_reset");
    check("rmiss.stall_in_reset", stall_mem, 1);
    tick();
    rst = 1'b0;
    tick();
    check_stat("rmiss.misses", STAT_MISSES, 4'd1);
    check_stat("rmiss.miss_cyc", STAT_MISS_CYC, 4'd1);
    bus.ready = 1'b1;
    bus.rdata = 32'h6543_2100;
    en = 1'b1;
    expect_wb(32'h6543_2100, 32'h0000_6000, 32'h0000_6666, 5'd3, RW_HALF, 1'b1);
    tick();
    check_wb("rmiss");
    idle();
    check_stat("rmiss.hits", STAT_HITS, 4'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
